// File: rtl/risc_mc_pkg.sv
// Shared encodings for the multi-cycle RISC control sequencer:
// FSM states, opcodes, mux select codes and ALU operation classes.
package risc_mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_MEM      = 3'd3,
    S_WB       = 3'd4,
    S_INT_PUSH = 3'd5,
    S_HALT     = 3'd6
  } state_e;

  localparam logic [5:0] OP_ALU_R = 6'd0;
  localparam logic [5:0] OP_ALU_I = 6'd1;
  localparam logic [5:0] OP_LD    = 6'd2;
  localparam logic [5:0] OP_ST    = 6'd3;
  localparam logic [5:0] OP_BR    = 6'd4;
  localparam logic [5:0] OP_CALL  = 6'd5;
  localparam logic [5:0] OP_RET   = 6'd6;
  localparam logic [5:0] OP_PUSH  = 6'd7;
  localparam logic [5:0] OP_POP   = 6'd8;
  localparam logic [5:0] OP_RETI  = 6'd9;
  localparam logic [5:0] OP_HALT  = 6'd63;

  localparam logic [1:0] MADDR_ALU   = 2'd0;
  localparam logic [1:0] MADDR_SP    = 2'd1;
  localparam logic [1:0] MADDR_SP_M4 = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_MEM    = 2'd2;

  localparam logic [2:0] AOP_ADD    = 3'd0;
  localparam logic [2:0] AOP_RTYPE  = 3'd1;
  localparam logic [2:0] AOP_ITYPE  = 3'd2;
  localparam logic [2:0] AOP_BRANCH = 3'd3;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LD, C_ST, C_BR, C_CALL, C_RET,
    C_PUSH, C_POP, C_RETI, C_HALT, C_ILLEGAL
  } iclass_e;

  function automatic iclass_e classify(input logic [5:0] op);
    case (op)
      OP_ALU_R: classify = C_ALU_R;
      OP_ALU_I: classify = C_ALU_I;
      OP_LD:    classify = C_LD;
      OP_ST:    classify = C_ST;
      OP_BR:    classify = C_BR;
      OP_CALL:  classify = C_CALL;
      OP_RET:   classify = C_RET;
      OP_PUSH:  classify = C_PUSH;
      OP_POP:   classify = C_POP;
      OP_RETI:  classify = C_RETI;
      OP_HALT:  classify = C_HALT;
      default:  classify = C_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/risc_mc_mem_timer.sv
// Bounded-wait counter shared by every state that waits on a memory ready.
// Counts consecutive not-ready cycles and flags the last allowed one.
module risc_mc_mem_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic active_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam int CW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  // Any cycle that ends the wait (ready, timeout or leaving the state) restarts the count.
  always_comb begin
    timeout_o = active_i && !ready_i && (count_q == LAST);
    count_d   = '0;
    if (active_i && !ready_i && !timeout_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/risc_mc_controller.sv
// Multi-cycle control sequencer: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB and takes interrupts at instruction boundaries.
module risc_mc_controller
  import risc_mc_pkg::*;
#(
  parameter int         OPW         = 6,
  parameter int         MEM_TIMEOUT = 16,
  parameter logic [1:0] ISR_SEL     = 2'd3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           interrupt,
  input  logic           imem_ready,
  input  logic           dmem_ready,
  output logic           imem_req,
  output logic           ir_load,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [1:0]     maddr_sel,
  output logic           wdata_sel,
  output logic           reg_write,
  output logic [1:0]     wb_src,
  output logic           alu_src,
  output logic [2:0]     alu_op,
  output logic           pc_write,
  output logic [1:0]     pc_src,
  output logic           sp_inc,
  output logic           sp_dec,
  output logic           int_ack,
  output logic           halted,
  output logic           illegal_op,
  output logic           bus_error,
  output logic [2:0]     state
);

  state_e  state_q, state_d;
  iclass_e iclass_q, iclass_d;
  logic    intMask_q, intMask_d;

  iclass_e decClass;
  state_e  boundary;
  logic    timerActive, memReady, timeout;
  logic    isWrite, popsSp, usesWb;
  logic [2:0] clsAluOp;
  logic       clsAluSrc;

  assign decClass    = classify(6'(opcode));
  assign timerActive = (state_q == S_FETCH) || (state_q == S_MEM) || (state_q == S_INT_PUSH);
  assign memReady    = (state_q == S_FETCH) ? imem_ready : dmem_ready;
  assign boundary    = (interrupt && !intMask_q) ? S_INT_PUSH : S_FETCH;
  assign isWrite     = (iclass_q == C_ST) || (iclass_q == C_PUSH) || (iclass_q == C_CALL);
  assign popsSp      = (iclass_q == C_POP) || (iclass_q == C_RET) || (iclass_q == C_RETI);
  assign usesWb      = (iclass_q == C_LD) || (iclass_q == C_POP);

  risc_mc_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .active_i  (timerActive),
    .ready_i   (memReady),
    .timeout_o (timeout)
  );

  // The ALU controls are held from EXEC through WB so the combinational ALU
  // result stays valid as the memory address and the writeback value.
  always_comb begin
    clsAluOp  = AOP_ADD;
    clsAluSrc = 1'b0;
    case (iclass_q)
      C_ALU_R: begin clsAluOp = AOP_RTYPE;  clsAluSrc = 1'b1; end
      C_ALU_I: begin clsAluOp = AOP_ITYPE;  clsAluSrc = 1'b0; end
      C_BR:    begin clsAluOp = AOP_BRANCH; clsAluSrc = 1'b1; end
      default: begin clsAluOp = AOP_ADD;    clsAluSrc = 1'b0; end
    endcase
  end

  // Next state and all outputs; everything is forced low while reset is held.
  always_comb begin
    state_d    = state_q;
    iclass_d   = iclass_q;
    intMask_d  = intMask_q;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    maddr_sel  = MADDR_ALU;
    wdata_sel  = 1'b0;
    reg_write  = 1'b0;
    wb_src     = WB_ALU;
    alu_src    = 1'b0;
    alu_op     = AOP_ADD;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    sp_inc     = 1'b0;
    sp_dec     = 1'b0;
    int_ack    = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    bus_error  = 1'b0;
    state      = 3'd0;
    if (!reset) begin
      state = state_q;
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_load = 1'b1;
            state_d = S_DECODE;
          end else if (timeout) begin
            bus_error = 1'b1;
            state_d   = S_HALT;
          end
        end
        S_DECODE: begin
          iclass_d = decClass;
          if (decClass == C_HALT) begin
            state_d = S_HALT;
          end else if (decClass == C_ILLEGAL) begin
            illegal_op = 1'b1;
            pc_write   = 1'b1;
            pc_src     = PC_PLUS4;
            state_d    = boundary;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          alu_op  = clsAluOp;
          alu_src = clsAluSrc;
          if (iclass_q == C_BR) begin
            pc_write = 1'b1;
            pc_src   = PC_BRANCH;
            state_d  = boundary;
          end else if ((iclass_q == C_ALU_R) || (iclass_q == C_ALU_I)) begin
            state_d = S_WB;
          end else begin
            state_d = S_MEM;
          end
        end
        S_MEM: begin
          alu_op    = clsAluOp;
          alu_src   = clsAluSrc;
          dmem_req  = 1'b1;
          dmem_we   = isWrite;
          wdata_sel = (iclass_q == C_CALL);
          if ((iclass_q == C_LD) || (iclass_q == C_ST)) maddr_sel = MADDR_ALU;
          else if (popsSp)                              maddr_sel = MADDR_SP;
          else                                          maddr_sel = MADDR_SP_M4;
          if (dmem_ready) begin
            sp_dec = (iclass_q == C_PUSH) || (iclass_q == C_CALL);
            sp_inc = popsSp;
            if (iclass_q == C_CALL) begin
              pc_write = 1'b1;
              pc_src   = PC_BRANCH;
            end else if ((iclass_q == C_RET) || (iclass_q == C_RETI)) begin
              pc_write = 1'b1;
              pc_src   = PC_MEM;
            end
            if (iclass_q == C_RETI) intMask_d = 1'b0;
            state_d = usesWb ? S_WB : boundary;
          end else if (timeout) begin
            bus_error = 1'b1;
            state_d   = S_HALT;
          end
        end
        S_WB: begin
          alu_op    = clsAluOp;
          alu_src   = clsAluSrc;
          reg_write = 1'b1;
          wb_src    = usesWb ? WB_MEM : WB_ALU;
          pc_write  = 1'b1;
          pc_src    = PC_PLUS4;
          state_d   = boundary;
        end
        S_INT_PUSH: begin
          dmem_req  = 1'b1;
          dmem_we   = 1'b1;
          maddr_sel = MADDR_SP_M4;
          wdata_sel = 1'b1;
          if (dmem_ready) begin
            sp_dec    = 1'b1;
            pc_write  = 1'b1;
            pc_src    = ISR_SEL;
            int_ack   = 1'b1;
            intMask_d = 1'b1;
            state_d   = S_FETCH;
          end else if (timeout) begin
            bus_error = 1'b1;
            state_d   = S_HALT;
          end
        end
        S_HALT: begin
          halted = 1'b1;
          if (interrupt && !intMask_q) state_d = S_INT_PUSH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      iclass_q  <= C_ILLEGAL;
      intMask_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      iclass_q  <= iclass_d;
      intMask_q <= intMask_d;
    end
  end

endmodule

// File: tb/tb_risc_mc_controller.sv
// Bench for risc_mc_controller: instruction-level generator expands each
// instruction into a per-cycle table of inputs and expected control outputs.
module tb_risc_mc_controller;

  localparam int TMO = 16;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_EXEC = 2, ST_MEM = 3;
  localparam int ST_WB = 4, ST_INTP = 5, ST_HALT = 6;

  localparam int OP_ALU_R = 0, OP_ALU_I = 1, OP_LD = 2, OP_ST = 3, OP_BR = 4;
  localparam int OP_CALL = 5, OP_RET = 6, OP_PUSH = 7, OP_POP = 8, OP_RETI = 9;
  localparam int OP_HALT = 63;

  typedef struct packed {
    logic [2:0] st;
    logic       imemReq, irLoad, dmemReq, dmemWe;
    logic [1:0] maddrSel;
    logic       wdataSel, regWrite;
    logic [1:0] wbSrc;
    logic       pcWrite;
    logic [1:0] pcSrc;
    logic       spInc, spDec, intAck, halted, illegalOp, busError;
  } exp_t;

  typedef struct {
    logic       rst, irdy, drdy, intr;
    logic [5:0] op;
    exp_t       exp;
    logic       chkAlu;
    logic [2:0] aluOp;
    logic       aluSrc;
  } cyc_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       interrupt, imem_ready, dmem_ready;
  logic       imem_req, ir_load, dmem_req, dmem_we, wdata_sel, reg_write;
  logic [1:0] maddr_sel, wb_src, pc_src;
  logic       alu_src, pc_write, sp_inc, sp_dec, int_ack, halted, illegal_op, bus_error;
  logic [2:0] alu_op, state;

  always #5 clk = ~clk;

  risc_mc_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .interrupt(interrupt),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .maddr_sel(maddr_sel), .wdata_sel(wdata_sel), .reg_write(reg_write), .wb_src(wb_src),
    .alu_src(alu_src), .alu_op(alu_op), .pc_write(pc_write), .pc_src(pc_src),
    .sp_inc(sp_inc), .sp_dec(sp_dec), .int_ack(int_ack), .halted(halted),
    .illegal_op(illegal_op), .bus_error(bus_error), .state(state)
  );

  cyc_t       vecs[$];
  int         checks = 0;
  int         errors = 0;
  logic [5:0] curOp;
  bit         mask;

  // A fresh cycle: don't-care inputs randomised, expected outputs idle.
  function automatic cyc_t newCyc(input int st);
    cyc_t c;
    c.rst    = 1'b0;
    c.irdy   = 1'($urandom);
    c.drdy   = 1'($urandom);
    c.intr   = 1'($urandom);
    c.op     = curOp;
    c.exp    = '0;
    c.exp.st = 3'(st);
    c.chkAlu = 1'b0;
    c.aluOp  = 3'd0;
    c.aluSrc = 1'b0;
    return c;
  endfunction

  task automatic genReset(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = newCyc(ST_FETCH);
      c.rst = 1'b1;
      vecs.push_back(c);
    end
    mask = 1'b0;
  endtask

  task automatic genFetch(input int waits, output bit tmo);
    cyc_t c;
    int n;
    curOp = 6'($urandom_range(0, 63));
    tmo = (waits >= TMO);
    n = tmo ? TMO : waits + 1;
    for (int i = 0; i < n; i++) begin
      c = newCyc(ST_FETCH);
      c.exp.imemReq = 1'b1;
      c.irdy = (!tmo && i == waits);
      c.exp.irLoad = c.irdy;
      c.exp.busError = (tmo && i == TMO - 1);
      vecs.push_back(c);
    end
  endtask

  function automatic cyc_t memBase(input int op);
    cyc_t c;
    c = newCyc(ST_MEM);
    c.exp.dmemReq  = 1'b1;
    c.exp.dmemWe   = (op == OP_ST || op == OP_PUSH || op == OP_CALL);
    c.exp.maddrSel = (op == OP_LD || op == OP_ST) ? 2'd0 :
                     (op == OP_PUSH || op == OP_CALL) ? 2'd2 : 2'd1;
    c.exp.wdataSel = (op == OP_CALL);
    return c;
  endfunction

  task automatic genMem(input int op, input int waits, output bit tmo);
    cyc_t c;
    int n;
    tmo = (waits >= TMO);
    n = tmo ? TMO : waits + 1;
    for (int i = 0; i < n; i++) begin
      c = memBase(op);
      c.drdy = (!tmo && i == waits);
      if (c.drdy) begin
        c.exp.spDec = (op == OP_PUSH || op == OP_CALL);
        c.exp.spInc = (op == OP_POP || op == OP_RET || op == OP_RETI);
        if (op == OP_CALL) begin c.exp.pcWrite = 1'b1; c.exp.pcSrc = 2'd1; end
        if (op == OP_RET || op == OP_RETI) begin c.exp.pcWrite = 1'b1; c.exp.pcSrc = 2'd2; end
      end
      c.exp.busError = (tmo && i == TMO - 1);
      vecs.push_back(c);
    end
  endtask

  function automatic cyc_t execCyc(input int op);
    cyc_t c;
    c = newCyc(ST_EXEC);
    c.chkAlu = 1'b1;
    case (op)
      OP_ALU_R: begin c.aluOp = 3'd1; c.aluSrc = 1'b1; end
      OP_ALU_I: begin c.aluOp = 3'd2; c.aluSrc = 1'b0; end
      OP_BR:    begin c.aluOp = 3'd3; c.aluSrc = 1'b1; end
      default:  begin c.aluOp = 3'd0; c.aluSrc = 1'b0; end
    endcase
    return c;
  endfunction

  task automatic genWb(input int op);
    cyc_t c;
    c = newCyc(ST_WB);
    c.exp.regWrite = 1'b1;
    c.exp.wbSrc    = (op == OP_LD || op == OP_POP) ? 2'd1 : 2'd0;
    c.exp.pcWrite  = 1'b1;
    vecs.push_back(c);
  endtask

  task automatic genIntPush(input int waits);
    cyc_t c;
    for (int i = 0; i <= waits; i++) begin
      c = newCyc(ST_INTP);
      c.exp.dmemReq  = 1'b1;
      c.exp.dmemWe   = 1'b1;
      c.exp.maddrSel = 2'd2;
      c.exp.wdataSel = 1'b1;
      c.drdy = (i == waits);
      if (c.drdy) begin
        c.exp.spDec = 1'b1; c.exp.pcWrite = 1'b1; c.exp.pcSrc = 2'd3; c.exp.intAck = 1'b1;
      end
      vecs.push_back(c);
    end
    mask = 1'b1;
  endtask

  // The last cycle of an instruction is where the interrupt level counts.
  task automatic boundary(input bit intr, input int iw, input bit clearMask);
    cyc_t c;
    bit take;
    c = vecs.pop_back();
    c.intr = intr;
    vecs.push_back(c);
    take = intr && !mask;
    if (clearMask) mask = 1'b0;
    if (take) genIntPush(iw);
  endtask

  task automatic genHaltCycle(input bit intr, input int iw);
    cyc_t c;
    c = newCyc(ST_HALT);
    c.exp.halted = 1'b1;
    c.intr = intr;
    vecs.push_back(c);
    if (intr && !mask) genIntPush(iw);
  endtask

  task automatic genInstr(input int op, input int fw, input int mw, input bit intr, input int iw);
    cyc_t c;
    bit tmo;
    genFetch(fw, tmo);
    if (tmo) return;
    curOp = 6'(op);
    c = newCyc(ST_DECODE);
    if (op == OP_HALT) begin vecs.push_back(c); return; end
    if (op > OP_RETI) begin
      c.exp.illegalOp = 1'b1;
      c.exp.pcWrite = 1'b1;
      vecs.push_back(c);
      boundary(intr, iw, 1'b0);
      return;
    end
    vecs.push_back(c);
    c = execCyc(op);
    if (op == OP_BR) begin
      c.exp.pcWrite = 1'b1; c.exp.pcSrc = 2'd1;
      vecs.push_back(c);
      boundary(intr, iw, 1'b0);
      return;
    end
    vecs.push_back(c);
    if (op == OP_ALU_R || op == OP_ALU_I) begin genWb(op); boundary(intr, iw, 1'b0); return; end
    genMem(op, mw, tmo);
    if (tmo) return;
    if (op == OP_LD || op == OP_POP) begin genWb(op); boundary(intr, iw, 1'b0); return; end
    boundary(intr, iw, op == OP_RETI);
  endtask

  task automatic genStAbort();
    cyc_t c;
    bit tmo;
    genFetch(0, tmo);
    curOp = 6'(OP_ST);
    vecs.push_back(newCyc(ST_DECODE));
    vecs.push_back(execCyc(OP_ST));
    c = memBase(OP_ST);
    c.drdy = 1'b0;
    vecs.push_back(c);
    genReset(1);
  endtask

  task automatic applyStimulus(input cyc_t c);
    reset      = c.rst;
    imem_ready = c.irdy;
    dmem_ready = c.drdy;
    interrupt  = c.intr;
    opcode     = c.op;
  endtask

  task automatic checkOutput(input cyc_t c, input int idx);
    exp_t act;
    act = {state, imem_req, ir_load, dmem_req, dmem_we, maddr_sel, wdata_sel, reg_write,
           wb_src, pc_write, pc_src, sp_inc, sp_dec, int_ack, halted, illegal_op, bus_error};
    checks++;
    if (act !== c.exp) begin
      errors++;
      $display("[TB] FAIL vec%0d controls: actual %h required %h (state actual %0d required %0d)",
               idx, act, c.exp, act.st, c.exp.st);
    end
    if (c.chkAlu) begin
      checks++;
      if ({alu_op, alu_src} !== {c.aluOp, c.aluSrc}) begin
        errors++;
        $display("[TB] FAIL vec%0d alu: actual op=%0d src=%0d required op=%0d src=%0d",
                 idx, alu_op, alu_src, c.aluOp, c.aluSrc);
      end
    end
  endtask

  initial begin
    int opsList[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 20, 45};
    bit tmo;
    reset = 1'b1; opcode = '0; interrupt = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    curOp = '0; mask = 1'b0;

    genReset(2);
    genInstr(OP_ALU_R, 0, 0, 1'b0, 0);
    genInstr(OP_LD, 0, 3, 1'b0, 0);
    genInstr(OP_ALU_R, 1, 0, 1'b1, 0);
    genInstr(OP_ALU_R, 0, 0, 1'b1, 0);
    genInstr(OP_RETI, 0, 1, 1'b1, 0);
    genInstr(OP_ALU_I, 0, 0, 1'b1, 2);
    genInstr(OP_RET, 0, 0, 1'b0, 0);
    genInstr(20, 0, 0, 1'b0, 0);
    genInstr(OP_ALU_I, 15, 0, 1'b0, 0);
    genInstr(OP_CALL, 0, 2, 1'b0, 0);
    genInstr(OP_PUSH, 0, 0, 1'b0, 0);
    genInstr(OP_POP, 0, 0, 1'b0, 0);
    genInstr(OP_BR, 0, 0, 1'b0, 0);
    genStAbort();
    genInstr(OP_ALU_R, 0, 0, 1'b0, 0);
    genFetch(TMO, tmo);
    for (int i = 0; i < 3; i++) genHaltCycle(1'b0, 0);
    genReset(1);
    genInstr(OP_LD, 0, TMO, 1'b0, 0);
    genHaltCycle(1'b0, 0);
    genReset(1);
    genInstr(OP_HALT, 0, 0, 1'b0, 0);
    genHaltCycle(1'b0, 0);
    genHaltCycle(1'b0, 0);
    genHaltCycle(1'b1, 1);
    genInstr(OP_RETI, 0, 0, 1'b0, 0);
    for (int i = 0; i < 40; i++) begin
      genInstr(opsList[$urandom_range(0, 11)], $urandom_range(0, 3), $urandom_range(0, 3),
               ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end
    genReset(1);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i], i);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
